control_unit: RTL
=================

// Module: control_unit
// PURPOSE
//  Microsequencer driving memory_system's control inputs. Fetches a 5-bit opcode
//  into IR, decodes it, issues per-cycle control words, and branches on C/N/P/Z.
//  Sits directly upstream of memory_system and consumes its instruction and flag outputs.
// PARAMETERS
//  PC_ADDR    3'd0    register-bank address of PC
//  DPTR_ADDR  3'd1    register-bank address of DPTR
//  A_ADDR     3'd2    register-bank address of A
//  TEMP_ADDR  3'd3    register-bank address of TEMP
//  ACC_ADDR   3'd4    register-bank address of ACC
//  OP_PASS    3'b000  selop code: pass busB to ALU output
//  OP_INC     3'b001  selop code: busB+1
//  OP_ADD     3'b010  selop code: A + busB
//  OP_SHR     3'b011  selop code: busB >> shamt
// PORTS
//  clk          in   1  system clock, rising edge
//  rst          in   1  asynchronous reset, active-low
//  instruction  in   5  opcode from IR (memory_system)
//  C,N,P,Z      in   1  ALU flags from memory_system
//  ir_sclr,mar_sclr     out 1  synchronous clear of IR / MAR
//  enaf         out  1  flag register update enable
//  selop        out  3  ALU operation select
//  shamt        out  2  shift amount
//  bank_wr_en   out  1  register bank write enable
//  busB_addr    out  3  bank read address onto bus B
//  busC_addr    out  3  bank write address from bus C
//  ir_en,mar_en out  1  IR / MAR load enable
//  wr_rdn       out  1  memory access: 1=write MDR to mem[MAR], 0=read
//  mdr_alu_n    out  1  bus C source: 1=MDR, 0=ALU
//  mdr_en       out  1  memory access strobe / MDR load
//  halted       out  1  1 while in HALT
//  illegal      out  1  1-cycle pulse in DECODE on an undefined opcode
// BEHAVIOUR
//  - Moore FSM; all outputs decode from registered state only (no input->output paths).
//  - rst=0 (async): state=INIT; every output 0 except ir_sclr=mar_sclr=1 (INIT word).
//  - INIT (1 cycle after release): ir_sclr=mar_sclr=1 -> F1.
//  - F1: busB=PC_ADDR, selop=OP_PASS, mar_en=1 -> F2.
//  - F2: mdr_en=1, wr_rdn=0; PC<-PC+1 (busB=busC=PC_ADDR, selop=OP_INC, bank_wr_en=1, mdr_alu_n=0) -> F3.
//  - F3: ir_en=1 -> DEC. Fetch = 3 cycles; instruction is sampled in DEC.
//  - DEC: 00000 NOP -> F1; 00001 LDA -> L1; 00010 STA -> S1; 00011 ADD -> X1;
//    00100 SLR -> R1; 00101 JZ -> J1; 11111 HLT -> HALT; any other: illegal=1 -> F1 (acts as NOP).
//  - L1: busB=DPTR, OP_PASS, mar_en=1 -> L2. L2: mdr_en=1, wr_rdn=0 -> L3.
//    L3: busC=A_ADDR, mdr_alu_n=1, bank_wr_en=1 -> F1.
//  - S1: busB=DPTR, OP_PASS, mar_en=1 -> S2. S2: busB=ACC, OP_PASS, mdr_alu_n=0, mdr_en=1, wr_rdn=1 -> F1.
//  - X1: busB=TEMP, selop=OP_ADD, busC=ACC, bank_wr_en=1, enaf=1 -> F1.
//  - R1: busB=busC=ACC, selop=OP_SHR, shamt=2'b01, bank_wr_en=1, enaf=1 -> F1.
//  - J1: if Z=1: busB=DPTR, busC=PC, OP_PASS, bank_wr_en=1; if Z=0: all enables 0. -> F1.
//    Z is the flag registered before J1 (last enaf cycle); only JZ reads flags.
//  - HALT: halted=1, all enables 0; held until rst.
//  - Enables not listed for a state are 0; selop/addresses default 0.
//  - enaf asserted only in X1 and R1; never two writers on bus C in one cycle.
//  - Unreachable state encodings recover to INIT on the next clock.
//  - rst mid-instruction aborts immediately; no partial writes after rst falls.
// TESTING
//  1 Release rst: cycle0 INIT ir_sclr=mar_sclr=1; next 3 cycles mar_en, mdr_en+bank_wr_en(busC=0,OP_INC), ir_en.
//  2 instruction=00011 in DEC -> X1 word: selop=010,busB=3,busC=4,bank_wr_en=1,enaf=1; then F1.
//  3 instruction=00101, Z=1 -> J1 busB=1,busC=0,bank_wr_en=1; repeat with Z=0 -> bank_wr_en=0.
//  4 instruction=00010 -> S1 mar_en=1 busB=1; S2 mdr_en=1 wr_rdn=1 busB=4; no bank_wr_en.
//  5 instruction=01101 -> illegal pulses 1 cycle, next state F1; 11111 -> halted=1 held 10 cycles.
//  6 Drop rst during L2 -> outputs immediately INIT word; after release fetch restarts at F1 pattern.

Source files
------------

// File: rtl/control_unit.sv
// -----------------------------------------------------------------------------
// control_unit
// Microsequencer for memory_system. Fetches an opcode into IR (3 cycles),
// decodes it, and issues one control word per cycle until the instruction
// completes. Only JZ reads the flags (Z).
//
// Ports
//   clk                  system clock, rising edge
//   rst                  asynchronous reset, active-low
//   instruction[4:0]     opcode held in IR
//   C, N, P, Z           ALU flags (Z used by JZ)
//   ir_sclr, mar_sclr    synchronous clear of IR / MAR
//   enaf                 flag register update enable
//   selop[2:0]           ALU operation select
//   shamt[1:0]           shift amount
//   bank_wr_en           register bank write enable
//   busB_addr[2:0]       bank read address onto bus B
//   busC_addr[2:0]       bank write address from bus C
//   ir_en, mar_en        IR / MAR load enable
//   wr_rdn               1 = write MDR to mem[MAR], 0 = read
//   mdr_alu_n            bus C source: 1 = MDR, 0 = ALU
//   mdr_en               memory access strobe / MDR load
//   halted               1 while halted
//   illegal              1-cycle pulse flagging an undefined opcode
//
// Every output comes straight from a flop. The flop is loaded with the
// control word of the state being entered, so the word is valid for the
// whole cycle that the state occupies. The opcode is only present in IR
// during DEC, so the registered illegal pulse appears in the cycle after
// DEC, together with the F1 word of the next fetch.
// -----------------------------------------------------------------------------
module control_unit #(
  parameter logic [2:0] PC_ADDR   = 3'd0,
  parameter logic [2:0] DPTR_ADDR = 3'd1,
  parameter logic [2:0] A_ADDR    = 3'd2,
  parameter logic [2:0] TEMP_ADDR = 3'd3,
  parameter logic [2:0] ACC_ADDR  = 3'd4,
  parameter logic [2:0] OP_PASS   = 3'b000,
  parameter logic [2:0] OP_INC    = 3'b001,
  parameter logic [2:0] OP_ADD    = 3'b010,
  parameter logic [2:0] OP_SHR    = 3'b011
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] instruction,
  input  logic       C,
  input  logic       N,
  input  logic       P,
  input  logic       Z,
  output logic       ir_sclr,
  output logic       mar_sclr,
  output logic       enaf,
  output logic [2:0] selop,
  output logic [1:0] shamt,
  output logic       bank_wr_en,
  output logic [2:0] busB_addr,
  output logic [2:0] busC_addr,
  output logic       ir_en,
  output logic       mar_en,
  output logic       wr_rdn,
  output logic       mdr_alu_n,
  output logic       mdr_en,
  output logic       halted,
  output logic       illegal
);

  typedef enum logic [3:0] {
    ST_INIT = 4'd0,  ST_F1 = 4'd1,  ST_F2 = 4'd2,  ST_F3 = 4'd3,
    ST_DEC  = 4'd4,  ST_L1 = 4'd5,  ST_L2 = 4'd6,  ST_L3 = 4'd7,
    ST_S1   = 4'd8,  ST_S2 = 4'd9,  ST_X1 = 4'd10, ST_R1 = 4'd11,
    ST_J1   = 4'd12, ST_HALT = 4'd13
  } state_t;

  typedef struct packed {
    logic       ir_sclr;
    logic       mar_sclr;
    logic       enaf;
    logic [2:0] selop;
    logic [1:0] shamt;
    logic       bank_wr_en;
    logic [2:0] busb;
    logic [2:0] busc;
    logic       ir_en;
    logic       mar_en;
    logic       wr_rdn;
    logic       mdr_alu_n;
    logic       mdr_en;
    logic       halted;
    logic       illegal;
  } ctrl_t;

  state_t state_r;
  state_t next_state_s;
  logic   ill_s;
  ctrl_t  ctrl_r;
  logic   unused_flags_s;

  // Only Z participates in sequencing; the other flags are not consumed.
  assign unused_flags_s = ^{C, N, P};

  // Control word for a state; z selects the taken/not-taken form of J1.
  function automatic ctrl_t word_of(input state_t st, input logic z, input logic ill);
    ctrl_t w;
    w = '0;
    case (st)
      ST_INIT: begin w.ir_sclr = 1'b1; w.mar_sclr = 1'b1; end
      ST_F1:   begin w.busb = PC_ADDR; w.selop = OP_PASS; w.mar_en = 1'b1; end
      ST_F2:   begin
        w.mdr_en = 1'b1; w.wr_rdn = 1'b0;
        w.busb = PC_ADDR; w.busc = PC_ADDR; w.selop = OP_INC;
        w.bank_wr_en = 1'b1; w.mdr_alu_n = 1'b0;
      end
      ST_F3:   begin w.ir_en = 1'b1; end
      ST_DEC:  begin w = '0; end
      ST_L1:   begin w.busb = DPTR_ADDR; w.selop = OP_PASS; w.mar_en = 1'b1; end
      ST_L2:   begin w.mdr_en = 1'b1; w.wr_rdn = 1'b0; end
      ST_L3:   begin w.busc = A_ADDR; w.mdr_alu_n = 1'b1; w.bank_wr_en = 1'b1; end
      ST_S1:   begin w.busb = DPTR_ADDR; w.selop = OP_PASS; w.mar_en = 1'b1; end
      ST_S2:   begin
        w.busb = ACC_ADDR; w.selop = OP_PASS; w.mdr_alu_n = 1'b0;
        w.mdr_en = 1'b1; w.wr_rdn = 1'b1;
      end
      ST_X1:   begin
        w.busb = TEMP_ADDR; w.selop = OP_ADD; w.busc = ACC_ADDR;
        w.bank_wr_en = 1'b1; w.enaf = 1'b1;
      end
      ST_R1:   begin
        w.busb = ACC_ADDR; w.busc = ACC_ADDR; w.selop = OP_SHR;
        w.shamt = 2'b01; w.bank_wr_en = 1'b1; w.enaf = 1'b1;
      end
      ST_J1:   begin
        if (z) begin
          w.busb = DPTR_ADDR; w.busc = PC_ADDR; w.selop = OP_PASS; w.bank_wr_en = 1'b1;
        end else begin
          w = '0;
        end
      end
      ST_HALT: begin w.halted = 1'b1; end
      default: begin w.ir_sclr = 1'b1; w.mar_sclr = 1'b1; end
    endcase
    w.illegal = ill;
    return w;
  endfunction

  // Next-state decode; undefined opcodes behave as NOP and raise ill_s.
  always_comb begin
    next_state_s = ST_INIT;
    ill_s        = 1'b0;
    case (state_r)
      ST_INIT: next_state_s = ST_F1;
      ST_F1:   next_state_s = ST_F2;
      ST_F2:   next_state_s = ST_F3;
      ST_F3:   next_state_s = ST_DEC;
      ST_DEC: begin
        case (instruction)
          5'b00000: next_state_s = ST_F1;
          5'b00001: next_state_s = ST_L1;
          5'b00010: next_state_s = ST_S1;
          5'b00011: next_state_s = ST_X1;
          5'b00100: next_state_s = ST_R1;
          5'b00101: next_state_s = ST_J1;
          5'b11111: next_state_s = ST_HALT;
          default: begin
            next_state_s = ST_F1;
            ill_s        = 1'b1;
          end
        endcase
      end
      ST_L1:   next_state_s = ST_L2;
      ST_L2:   next_state_s = ST_L3;
      ST_L3:   next_state_s = ST_F1;
      ST_S1:   next_state_s = ST_S2;
      ST_S2:   next_state_s = ST_F1;
      ST_X1:   next_state_s = ST_F1;
      ST_R1:   next_state_s = ST_F1;
      ST_J1:   next_state_s = ST_F1;
      ST_HALT: next_state_s = ST_HALT;
      default: next_state_s = ST_INIT;
    endcase
  end

  // State and output registers; reset forces the INIT word at once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r          <= ST_INIT;
      ctrl_r           <= '0;
      ctrl_r.ir_sclr   <= 1'b1;
      ctrl_r.mar_sclr  <= 1'b1;
    end else begin
      state_r <= next_state_s;
      ctrl_r  <= word_of(next_state_s, Z, ill_s);
    end
  end

  assign ir_sclr    = ctrl_r.ir_sclr;
  assign mar_sclr   = ctrl_r.mar_sclr;
  assign enaf       = ctrl_r.enaf;
  assign selop      = ctrl_r.selop;
  assign shamt      = ctrl_r.shamt;
  assign bank_wr_en = ctrl_r.bank_wr_en;
  assign busB_addr  = ctrl_r.busb;
  assign busC_addr  = ctrl_r.busc;
  assign ir_en      = ctrl_r.ir_en;
  assign mar_en     = ctrl_r.mar_en;
  assign wr_rdn     = ctrl_r.wr_rdn;
  assign mdr_alu_n  = ctrl_r.mdr_alu_n;
  assign mdr_en     = ctrl_r.mdr_en;
  assign halted     = ctrl_r.halted;
  assign illegal    = ctrl_r.illegal;

endmodule
